// File: rtl/spi_fifo_sequencer.sv
// spi_fifo_sequencer
// SPI mode-0 master engine between the APB FIFO bridge and the SPI pins.
// It pops a word from the TX FIFO and shifts it out MSB-first on mosi while
// capturing miso. It then pushes the captured word into the RX FIFO. cs_n stays
// low across back-to-back words. When the RX FIFO is full, the engine stalls
// in DONE and does not drop the word.
//
// Ports:
//   pclk, presetn            clock, synchronous active-low reset
//   enable                   level; permits starting new words
//   empty_tx, fifo_r_data_tx TX FIFO status / head word
//   read_fifo_tx             one-cycle TX pop strobe
//   full_rx                  RX FIFO full
//   write_fifo_rx            one-cycle RX push strobe
//   fifo_w_data_rx           captured word, qualified by write_fifo_rx
//   sclk, mosi, miso, cs_n   SPI pins (sclk idles low, cs_n active-low)
//   busy                     high whenever the engine is not IDLE
//   words_done               wrapping count of words pushed to RX
module spi_fifo_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  enable,
  input  logic                  empty_tx,
  input  logic [DATA_WIDTH-1:0] fifo_r_data_tx,
  output logic                  read_fifo_tx,
  input  logic                  full_rx,
  output logic                  write_fifo_rx,
  output logic [DATA_WIDTH-1:0] fifo_w_data_rx,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy,
  output logic [15:0]           words_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  start;
  logic                  div_tick, rise, fall, last_fall;

  assign div_tick  = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign rise      = div_tick && !sclk;
  assign fall      = div_tick && sclk;
  assign last_fall = fall && (bit_cnt == BIT_LAST);

  assign mosi           = tx_sr[DATA_WIDTH-1];
  assign fifo_w_data_rx = rx_sr;
  assign busy           = (state != IDLE);

  always_ff @(posedge pclk) begin
    if (!presetn) state <= IDLE;
    else          state <= state_next;
  end

  // Strobes are gated by presetn so that no word is popped or pushed
  // during a reset cycle, while the state register still shows the old state.
  always_comb begin
    state_next    = state;
    read_fifo_tx  = 1'b0;
    write_fifo_rx = 1'b0;
    start         = 1'b0;
    if (presetn) begin
      case (state)
        IDLE: begin
          if (enable && !empty_tx) begin
            read_fifo_tx = 1'b1;
            start        = 1'b1;
            state_next   = SHIFT;
          end
        end
        SHIFT: begin
          if (last_fall) state_next = DONE;
        end
        DONE: begin
          if (!full_rx) begin
            write_fifo_rx = 1'b1;
            if (enable && !empty_tx) begin
              read_fifo_tx = 1'b1;
              start        = 1'b1;
              state_next   = SHIFT;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      words_done <= '0;
    end else begin
      // cs_n only rises when the next state is IDLE. A reload from DONE therefore
      // keeps the select low between back-to-back words.
      cs_n <= (state_next == IDLE);
      if (write_fifo_rx) words_done <= words_done + 16'd1;
      if (start) begin
        tx_sr   <= fifo_r_data_tx;
        rx_sr   <= '0;
        bit_cnt <= '0;
        div_cnt <= '0;
        sclk    <= 1'b0;
      end else if (state == SHIFT) begin
        if (div_tick) begin
          div_cnt <= '0;
          sclk    <= !sclk;
          if (rise) rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
          if (fall && !last_fall) begin
            tx_sr   <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_fifo_sequencer.sv
`timescale 1ns/1ps
module tb_spi_fifo_sequencer;
  localparam int DW = 8;
  localparam int CD = 2;

  logic          pclk = 1'b0;
  logic          presetn, enable, full_rx;
  logic          empty_tx, read_fifo_tx, write_fifo_rx;
  logic          sclk, mosi, miso, cs_n, busy;
  logic [DW-1:0] fifo_r_data_tx, fifo_w_data_rx;
  logic [15:0]   words_done;

  // TX FIFO model (written by the stimulus, popped by the strobe process)
  logic [DW-1:0] tx_mem    [0:15];
  logic [DW-1:0] slave_mem [0:15];
  logic [3:0]    wr_ptr;
  logic [3:0]    rd_ptr   = '0;
  logic [DW-1:0] slave_sr = '0;
  logic          sclk_q   = 1'b0;
  int            inv_bad  = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  assign empty_tx       = (wr_ptr == rd_ptr);
  assign fifo_r_data_tx = tx_mem[rd_ptr];
  assign miso           = slave_sr[DW-1];

  spi_fifo_sequencer #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .pclk(pclk), .presetn(presetn), .enable(enable),
    .empty_tx(empty_tx), .fifo_r_data_tx(fifo_r_data_tx), .read_fifo_tx(read_fifo_tx),
    .full_rx(full_rx), .write_fifo_rx(write_fifo_rx), .fifo_w_data_rx(fifo_w_data_rx),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n),
    .busy(busy), .words_done(words_done)
  );

  // FIFO pop plus mode-0 slave: the slave loads its reply at the pop and
  // advances after each falling sclk.
  always @(posedge pclk) begin
    sclk_q <= sclk;
    if (read_fifo_tx && !empty_tx) begin
      slave_sr <= slave_mem[rd_ptr];
      rd_ptr   <= rd_ptr + 4'd1;
    end else if (sclk_q && !sclk) begin
      slave_sr <= {slave_sr[DW-2:0], 1'b0};
    end
    if ((read_fifo_tx && empty_tx) || (write_fifo_rx && full_rx)) inv_bad <= inv_bad + 1;
  end

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
    int         exp_lat;
  } vec_t;
  vec_t vecs [5];

  logic [7:0] mbits;
  int         rises;
  int         cs_bad;
  logic       prev_sclk;
  int         exp_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] t, input logic [7:0] s);
    tx_mem[wr_ptr]    = t;
    slave_mem[wr_ptr] = s;
    wr_ptr            = wr_ptr + 4'd1;
  endtask

  task automatic begin_word();
    mbits = '0;
    rises = 0;
  endtask

  task automatic step();
    @(negedge pclk);
    if (cs_n !== 1'b0) cs_bad++;
    if (!prev_sclk && sclk) begin
      mbits = {mbits[6:0], mosi};
      rises++;
    end
    prev_sclk = sclk;
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (read_fifo_tx) begin
        ok = 1'b1;
        return;
      end
      @(negedge pclk);
    end
  endtask

  task automatic to_push(output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      cyc++;
      if (write_fifo_rx) return;
    end
    cyc = 9999;
  endtask

  initial begin
    bit ok;
    int lat, bad;

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 33};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 33};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 33};
    vecs[3] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3, 33};
    vecs[4] = '{8'h81, 8'h7E, 8'h81, 8'h7E, 33};

    presetn = 1'b0; enable = 1'b0; full_rx = 1'b0; wr_ptr = '0;
    prev_sclk = 1'b0; cs_bad = 0; exp_wd = 0;
    repeat (2) @(negedge pclk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words_done", 32'(words_done), 32'd0);
    check("rst_strobes", 32'({read_fifo_tx, write_fifo_rx}), 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    // Single-word vectors
    enable = 1'b1;
    for (int v = 0; v < 5; v++) begin
      push_word(vecs[v].tx, vecs[v].slv);
      wait_pop(ok);
      check($sformatf("v%0d_pop", v), 32'(ok), 32'd1);
      begin_word();
      cs_bad = 0;
      to_push(lat);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_rx_data", v), 32'(fifo_w_data_rx), 32'(vecs[v].exp_rx));
      check($sformatf("v%0d_mosi_bits", v), 32'(mbits), 32'(vecs[v].exp_mosi));
      check($sformatf("v%0d_rises", v), 32'(rises), 32'd8);
      check($sformatf("v%0d_cs_low", v), 32'(cs_bad), 32'd0);
      check($sformatf("v%0d_one_pop", v), 32'(rd_ptr), 32'(wr_ptr));
      exp_wd++;
      @(negedge pclk);
      check($sformatf("v%0d_cs_high_after", v), 32'({cs_n, busy}), 32'b10);
      check($sformatf("v%0d_words_done", v), 32'(words_done), 32'(exp_wd));
    end

    // Back-to-back: three words, cs_n low throughout
    enable = 1'b0;
    push_word(8'h01, 8'h12);
    push_word(8'h80, 8'h34);
    push_word(8'hFF, 8'h56);
    enable = 1'b1;
    wait_pop(ok);
    check("b2b_pop0", 32'(ok), 32'd1);
    cs_bad = 0;
    begin_word();
    to_push(lat);
    check("b2b_lat0", 32'(lat), 32'd33);
    check("b2b_data0", 32'(fifo_w_data_rx), 32'h12);
    check("b2b_mosi0", 32'(mbits), 32'h01);
    check("b2b_pop1_same_cycle", 32'(read_fifo_tx), 32'd1);
    begin_word();
    to_push(lat);
    check("b2b_lat1", 32'(lat), 32'd33);
    check("b2b_data1", 32'(fifo_w_data_rx), 32'h34);
    check("b2b_mosi1", 32'(mbits), 32'h80);
    check("b2b_pop2_same_cycle", 32'(read_fifo_tx), 32'd1);
    begin_word();
    to_push(lat);
    check("b2b_lat2", 32'(lat), 32'd33);
    check("b2b_data2", 32'(fifo_w_data_rx), 32'h56);
    check("b2b_mosi2", 32'(mbits), 32'hFF);
    check("b2b_no_pop_last", 32'(read_fifo_tx), 32'd0);
    check("b2b_cs_low", 32'(cs_bad), 32'd0);
    exp_wd += 3;
    @(negedge pclk);
    check("b2b_cs_high_after", 32'(cs_n), 32'd1);
    check("b2b_words_done", 32'(words_done), 32'(exp_wd));

    // RX full stall for 5 cycles
    push_word(8'h3E, 8'h9C);
    full_rx = 1'b1;
    wait_pop(ok);
    check("stall_pop", 32'(ok), 32'd1);
    begin_word();
    cs_bad = 0;
    repeat (33) step();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (write_fifo_rx || sclk || cs_n || !busy || read_fifo_tx) bad++;
      step();
    end
    check("stall_hold", 32'(bad), 32'd0);
    check("stall_words_done", 32'(words_done), 32'(exp_wd));
    full_rx = 1'b0;
    #1;
    check("stall_push", 32'(write_fifo_rx), 32'd1);
    check("stall_data", 32'(fifo_w_data_rx), 32'h9C);
    check("stall_mosi", 32'(mbits), 32'h3E);
    check("stall_cs_low", 32'(cs_bad), 32'd0);
    exp_wd++;
    @(negedge pclk);
    check("stall_cs_high_after", 32'(cs_n), 32'd1);
    check("stall_words_done_after", 32'(words_done), 32'(exp_wd));

    // Enable dropped at bit 3 with two words queued
    push_word(8'h6C, 8'h11);
    push_word(8'h93, 8'h22);
    wait_pop(ok);
    check("endrop_pop", 32'(ok), 32'd1);
    begin_word();
    repeat (14) step();
    enable = 1'b0;
    to_push(lat);
    check("endrop_lat", 32'(lat), 32'd19);
    check("endrop_data", 32'(fifo_w_data_rx), 32'h11);
    check("endrop_mosi", 32'(mbits), 32'h6C);
    check("endrop_no_pop_at_push", 32'(read_fifo_tx), 32'd0);
    exp_wd++;
    @(negedge pclk);
    check("endrop_idle", 32'({cs_n, busy}), 32'b10);
    bad = 0;
    repeat (20) begin
      @(negedge pclk);
      if (read_fifo_tx || busy) bad++;
    end
    check("endrop_stays_idle", 32'(bad), 32'd0);
    check("endrop_queued", 32'(wr_ptr - rd_ptr), 32'd1);
    enable = 1'b1;
    wait_pop(ok);
    check("endrop_resume_pop", 32'(ok), 32'd1);
    begin_word();
    to_push(lat);
    check("endrop_resume_data", 32'(fifo_w_data_rx), 32'h22);
    exp_wd++;
    @(negedge pclk);
    check("endrop_words_done", 32'(words_done), 32'(exp_wd));

    // Reset in the middle of bit 4
    push_word(8'h47, 8'h5B);
    push_word(8'hB2, 8'h66);
    wait_pop(ok);
    check("rstmid_pop", 32'(ok), 32'd1);
    begin_word();
    repeat (18) step();
    presetn = 1'b0;
    @(negedge pclk);
    check("rstmid_cs_sclk", 32'({cs_n, sclk}), 32'b10);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_words_done", 32'(words_done), 32'd0);
    check("rstmid_no_strobes", 32'({write_fifo_rx, read_fifo_tx}), 32'd0);
    check("rstmid_word_lost", 32'(wr_ptr - rd_ptr), 32'd1);
    presetn = 1'b1;
    wait_pop(ok);
    check("rstmid_restart_pop", 32'(ok), 32'd1);
    begin_word();
    cs_bad = 0;
    to_push(lat);
    check("rstmid_lat", 32'(lat), 32'd33);
    check("rstmid_data", 32'(fifo_w_data_rx), 32'h66);
    check("rstmid_mosi", 32'(mbits), 32'hB2);
    check("rstmid_cs_low", 32'(cs_bad), 32'd0);
    @(negedge pclk);
    check("rstmid_words_done_after", 32'(words_done), 32'd1);

    // Empty TX with enable high
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      if (read_fifo_tx || busy || !cs_n || sclk) bad++;
    end
    check("empty_idle", 32'(bad), 32'd0);

    check("strobe_invariants", 32'(inv_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
